ifetch_pc_unit: RTL and testbench

// - Instruction-fetch and PC-sequencing unit of the MIPS core. It is the producer of the ALU's
//   pc (PC+4) input and the consumer of its AddrResult/Zero outputs.
// - Holds the PC and fetches words from an instruction memory with variable latency.
// - Presents each instruction to decode/execute and, on retirement, selects the next PC:

---
 rtl/cpu_defs_pkg.sv | 22 ++
 rtl/next_pc_sel.sv | 35 +++
 rtl/ifetch_pc_unit.sv | 111 +++++++++++
 tb/tb_ifetch_pc_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the fetch/PC sequencing unit: FSM encoding, reset PC,
// jump opcodes and the j/jal target builder.
package cpu_defs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [5:0]  J_OPC        = 6'h2;
   localparam logic [5:0]  JAL_OPC      = 6'h3;

   // Pseudo-direct target: region bits come from PC+4, not the PC itself.
   function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                               input logic [25:0] idx);
      return {pc4[31:28], idx, 2'b00};
   endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (jr > j/jal > taken branch > sequential) and the
// word-alignment check on the selected target.
module next_pc_sel
   import cpu_defs_pkg::*;
(
   input  logic [31:0] i_pc_plus4,
   input  logic [25:0] i_jidx,
   input  logic [31:0] i_addr_result,
   input  logic        i_zero,
   input  logic        i_branch,
   input  logic        i_nbranch,
   input  logic        i_jmp,
   input  logic        i_jal,
   input  logic        i_jr,
   output logic [31:0] o_next_pc,
   output logic        o_misaligned
);

   logic w_taken;

   assign w_taken = (i_branch & i_zero) | (i_nbranch & ~i_zero);

   always_comb begin
      o_next_pc = i_pc_plus4;
      if (i_jr)
         o_next_pc = i_addr_result;
      else if (i_jmp | i_jal)
         o_next_pc = jump_target(i_pc_plus4, i_jidx);
      else if (w_taken)
         o_next_pc = i_addr_result;
   end

   assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/ifetch_pc_unit.sv
// Instruction fetch and PC sequencing: fetches one word at a time from a
// variable-latency memory, holds it for execute, and redirects on retirement.
module ifetch_pc_unit
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
   parameter int          IMEM_ADDR_W = 14
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   imem_req,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   input  logic                   imem_ready,
   input  logic [31:0]            imem_rdata,
   output logic [31:0]            instr,
   output logic                   instr_valid,
   input  logic                   instr_ack,
   output logic [31:0]            pc_out,
   output logic [31:0]            pc_plus4,
   input  logic [31:0]            addr_result,
   input  logic                   zero,
   input  logic                   branch,
   input  logic                   nbranch,
   input  logic                   jmp,
   input  logic                   jal,
   input  logic                   jr,
   output logic                   fault,
   output logic [31:0]            instret
);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_req;
   logic        r_valid;
   logic        r_fault;
   logic [31:0] r_instret;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_next_pc;
   logic        w_misaligned;

   assign w_pc_plus4 = r_pc + 32'd4;

   next_pc_sel u_next_pc_sel (
      .i_pc_plus4    (w_pc_plus4),
      .i_jidx        (r_instr[25:0]),
      .i_addr_result (addr_result),
      .i_zero        (zero),
      .i_branch      (branch),
      .i_nbranch     (nbranch),
      .i_jmp         (jmp),
      .i_jal         (jal),
      .i_jr          (jr),
      .o_next_pc     (w_next_pc),
      .o_misaligned  (w_misaligned)
   );

   // req/valid are registered alongside the state so they change only on edges.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_pc      <= RESET_PC;
         r_instr   <= '0;
         r_req     <= 1'b0;
         r_valid   <= 1'b0;
         r_fault   <= 1'b0;
         r_instret <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_FETCH;
               r_req   <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_ready) begin
                  r_instr <= imem_rdata;
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (instr_ack) begin
                  r_valid <= 1'b0;
                  if (w_misaligned) begin
                     r_fault <= 1'b1;
                     r_state <= ST_FAULT;
                  end else begin
                     r_pc      <= w_next_pc;
                     r_instret <= r_instret + 32'd1;
                     r_req     <= 1'b1;
                     r_state   <= ST_FETCH;
                  end
               end
            end
            ST_FAULT: ;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc[IMEM_ADDR_W+1:2];
   assign instr       = r_instr;
   assign instr_valid = r_valid;
   assign pc_out      = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign fault       = r_fault;
   assign instret     = r_instret;

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// Directed bench for ifetch_pc_unit: drives on the falling edge, checks on the
// next falling edge against hand-computed values.
module tb_ifetch_pc_unit;
   import cpu_defs_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [13:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ack;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic [31:0] addr_result;
   logic        zero, branch, nbranch, jmp, jal, jr;
   logic        fault;
   logic [31:0] instret;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clock = ~clock;

   ifetch_pc_unit #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(14)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
      .pc_out(pc_out), .pc_plus4(pc_plus4),
      .addr_result(addr_result), .zero(zero),
      .branch(branch), .nbranch(nbranch), .jmp(jmp), .jal(jal), .jr(jr),
      .fault(fault), .instret(instret)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic clr_ctl;
      instr_ack = 0; zero = 0; branch = 0; nbranch = 0;
      jmp = 0; jal = 0; jr = 0; addr_result = '0;
   endtask

   // Precondition: unit sits in FETCH.
   task automatic fetch(input logic [31:0] w);
      imem_ready = 1; imem_rdata = w;
      tick;
      imem_ready = 0;
   endtask

   task automatic retire(input logic t_jr, input logic t_jmp, input logic t_jal,
                         input logic t_br, input logic t_nbr, input logic t_z,
                         input logic [31:0] t_addr);
      jr = t_jr; jmp = t_jmp; jal = t_jal; branch = t_br; nbranch = t_nbr;
      zero = t_z; addr_result = t_addr; instr_ack = 1;
      tick;
      clr_ctl;
   endtask

   task automatic goto_pc(input logic [31:0] pc);
      fetch(32'h0000_0000);
      retire(1, 0, 0, 0, 0, 0, pc);
   endtask

   initial begin
      logic [31:0] w_op;
      clr_ctl;
      imem_ready = 0; imem_rdata = '0; reset = 1;
      @(negedge clock);
      tick; tick;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instret", instret, 32'h0);
      chk("rst_fault", {31'd0, fault}, 32'd0);

      // zero-wait memory
      reset = 0; imem_ready = 1; imem_rdata = 32'h2008_0005;
      tick;
      chk("zw_req", {31'd0, imem_req}, 32'd1);
      chk("zw_addr", {18'd0, imem_addr}, 32'd0);
      chk("zw_valid0", {31'd0, instr_valid}, 32'd0);
      tick;
      imem_ready = 0;
      chk("zw_valid1", {31'd0, instr_valid}, 32'd1);
      chk("zw_instr", instr, 32'h2008_0005);
      chk("zw_pc4", pc_plus4, 32'h4);
      chk("zw_req_hold", {31'd0, imem_req}, 32'd0);
      retire(0, 0, 0, 0, 0, 0, 32'h0);
      chk("zw_pc", pc_out, 32'h4);
      chk("zw_instret", instret, 32'h1);

      // memory stalls three cycles
      for (int i = 0; i < 3; i++) begin
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", {18'd0, imem_addr}, 32'd1);
         chk("wait_valid", {31'd0, instr_valid}, 32'd0);
         tick;
      end
      fetch(32'h0000_0020);
      chk("wait_valid_after", {31'd0, instr_valid}, 32'd1);
      repeat (3) tick;
      chk("hold_no_req", {31'd0, imem_req}, 32'd0);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      retire(1, 0, 0, 0, 0, 0, 32'h40);
      chk("jr_to_40", pc_out, 32'h40);

      // branches at pc=0x40
      fetch(32'h1000_000F);
      retire(0, 0, 0, 1, 0, 1, 32'h80);
      chk("beq_taken", pc_out, 32'h80);
      goto_pc(32'h40);
      fetch(32'h1000_000F);
      retire(0, 0, 0, 1, 0, 0, 32'h80);
      chk("beq_not_taken", pc_out, 32'h44);
      goto_pc(32'h40);
      fetch(32'h1400_000F);
      retire(0, 0, 0, 0, 1, 0, 32'h80);
      chk("bne_taken", pc_out, 32'h80);

      // jal, then jr beating j
      goto_pc(32'h1000_0000);
      fetch(32'h0C00_0010);
      chk("jal_pc4", pc_plus4, 32'h1000_0004);
      w_op = instr;
      chk("jal_opc", {26'd0, w_op[31:26]}, {26'd0, JAL_OPC});
      retire(0, 0, 1, 0, 0, 0, 32'hDEAD_0000);
      chk("jal_target", pc_out, 32'h1000_0040);
      fetch(32'h0800_0020);
      retire(1, 1, 0, 0, 0, 0, 32'h200);
      chk("jr_over_j", pc_out, 32'h200);

      // PC wrap and address truncation
      goto_pc(32'hFFFF_FFFC);
      chk("wrap_addr", {18'd0, imem_addr}, 32'h3FFF);
      fetch(32'h0);
      retire(0, 0, 0, 0, 0, 0, 32'h0);
      chk("wrap_pc", pc_out, 32'h0);

      // misaligned jr -> sticky fault
      goto_pc(32'h200);
      fetch(32'h0);
      retire(1, 0, 0, 0, 0, 0, 32'h42);
      chk("flt_fault", {31'd0, fault}, 32'd1);
      chk("flt_pc", pc_out, 32'h200);
      chk("flt_valid", {31'd0, instr_valid}, 32'd0);
      imem_ready = 1;
      repeat (3) tick;
      imem_ready = 0;
      chk("flt_no_req", {31'd0, imem_req}, 32'd0);
      chk("flt_sticky", {31'd0, fault}, 32'd1);
      reset = 1; tick; tick; reset = 0;
      chk("flt_rst_pc", pc_out, 32'h0);
      chk("flt_rst_fault", {31'd0, fault}, 32'd0);

      // reset while waiting on ready
      tick;
      chk("mid_req", {31'd0, imem_req}, 32'd1);
      reset = 1;
      tick;
      chk("mid_req_drop", {31'd0, imem_req}, 32'd0);
      reset = 0; imem_ready = 1; imem_rdata = 32'hFFFF_FFFF;
      tick;
      imem_ready = 0;
      chk("mid_late_ready", {31'd0, instr_valid}, 32'd0);
      chk("mid_refetch", {31'd0, imem_req}, 32'd1);

      // retirement counter wrap
      fetch(32'h0);
      force dut.r_instret = 32'hFFFF_FFFF;
      #1 release dut.r_instret;
      retire(0, 0, 0, 0, 0, 0, 32'h0);
      chk("instret_wrap", instret, 32'h0);
      chk("instret_pc", pc_out, 32'h4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
